memory_unit_2: RTL and testbench



---
 rtl/memory_unit_2_pkg.sv | 14 +
 rtl/memory_array_2.sv | 25 ++
 rtl/memory_unit_2.sv | 125 ++++++++++++
 tb/tb_memory_unit_2.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_2_pkg.sv
// Shared processor definitions: data/address width defaults and the memory FSM
// state encoding used by memory_unit_2.
package memory_unit_2_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_array_2.sv
// Single-port synchronous RAM; storage is never reset.
module memory_array_2 #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_unit_2.sv
// Word-addressed data memory responder: request/ready accept, programmable wait
// states, one-cycle ack carrying read data or an error flag.
module memory_unit_2
    import memory_unit_2_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              MEM_clk,
    input  logic              MEM_rst,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_data_in,
    input  logic              MEM_req,
    input  logic              MEM_rd_en,
    input  logic              MEM_wr_en,
    output logic              MEM_ready,
    output logic              MEM_ack,
    output logic              MEM_err,
    output logic [DATA_W-1:0] MEM_data_out,
    output mem_state_t        MEM_state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    // Handshake: a request is taken at a posedge where MEM_req & MEM_ready;
    // the requester holds or re-issues while MEM_ready is low (no queuing).

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_q;
    logic              wr_q;
    logic              data_valid;
    logic [DATA_W-1:0] ram_dout;

    logic commit;
    logic in_range;
    logic access_ok;
    logic ram_we;
    logic ram_re;

    assign commit    = (state == MEM_WAIT) && (cnt == '0);
    assign in_range  = (addr_q >> AW) == '0;
    assign access_ok = (rd_q ^ wr_q) && in_range;
    assign ram_we    = commit && access_ok && wr_q;
    assign ram_re    = commit && access_ok && rd_q;

    assign MEM_state = state;

    always_ff @(posedge MEM_clk) begin
        if (MEM_rst) begin
            state      <= MEM_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            MEM_ready  <= 1'b1;
            MEM_ack    <= 1'b0;
            MEM_err    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    MEM_ack <= 1'b0;
                    MEM_err <= 1'b0;
                    if (MEM_req) begin
                        addr_q    <= MEM_addr;
                        data_q    <= MEM_data_in;
                        rd_q      <= MEM_rd_en;
                        wr_q      <= MEM_wr_en;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        MEM_ready <= 1'b0;
                        state     <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        MEM_ack <= 1'b1;
                        MEM_err <= !access_ok;
                        if (ram_re) begin
                            data_valid <= 1'b1;
                        end
                        state <= MEM_RESP;
                    end
                end
                MEM_RESP: begin
                    MEM_ack   <= 1'b0;
                    MEM_err   <= 1'b0;
                    MEM_ready <= 1'b1;
                    state     <= MEM_IDLE;
                end
                default: begin
                    MEM_ack   <= 1'b0;
                    MEM_err   <= 1'b0;
                    MEM_ready <= 1'b1;
                    state     <= MEM_IDLE;
                end
            endcase
        end
    end

    // The RAM output register holds the last committed read; it reads as zero
    // until the first read completes after reset, since the RAM itself has no reset.
    assign MEM_data_out = data_valid ? ram_dout : '0;

    memory_array_2 #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk (MEM_clk),
        .we  (ram_we),
        .re  (ram_re),
        .addr(addr_q[AW-1:0]),
        .din (data_q),
        .dout(ram_dout)
    );

endmodule

// File: tb/tb_memory_unit_2.sv
// Bench for memory_unit_2: directed plus random accesses on a WAIT_CYCLES=2 and
// a WAIT_CYCLES=0 instance, checked against an array model of the memory.
module tb_memory_unit_2;
    import memory_unit_2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] addr;
    logic [15:0] din;
    logic        sel;

    logic        ready2, ack2, err2, ready0, ack0, err0;
    logic [15:0] dout2, dout0;
    mem_state_t  state2, state0;

    logic        ready_m, ack_m, err_m;
    logic [15:0] dout_m;
    mem_state_t  state_m;

    assign ready_m = sel ? ready0 : ready2;
    assign ack_m   = sel ? ack0   : ack2;
    assign err_m   = sel ? err0   : err2;
    assign dout_m  = sel ? dout0  : dout2;
    assign state_m = sel ? state0 : state2;

    memory_unit_2 #(.WAIT_CYCLES(2)) dut2 (
        .MEM_clk(clk), .MEM_rst(rst), .MEM_addr(addr), .MEM_data_in(din),
        .MEM_req(req & ~sel), .MEM_rd_en(rd_en), .MEM_wr_en(wr_en),
        .MEM_ready(ready2), .MEM_ack(ack2), .MEM_err(err2),
        .MEM_data_out(dout2), .MEM_state(state2)
    );

    memory_unit_2 #(.WAIT_CYCLES(0)) dut0 (
        .MEM_clk(clk), .MEM_rst(rst), .MEM_addr(addr), .MEM_data_in(din),
        .MEM_req(req & sel), .MEM_rd_en(rd_en), .MEM_wr_en(wr_en),
        .MEM_ready(ready0), .MEM_ack(ack0), .MEM_err(err0),
        .MEM_data_out(dout0), .MEM_state(state0)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [15:0] model_mem  [2][256];
    bit          known      [2][256];
    logic [15:0] model_dout [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wc_of(input logic s);
        return s ? 0 : 2;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_dout[0] = 16'h0000;
        model_dout[1] = 16'h0000;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input string tag);
        int  s;
        int  lat;
        bit  e;
        s = sel ? 1 : 0;
        for (int i = 0; i < 20 && !ready_m; i++) @(negedge clk);
        check({tag, " ready"}, 32'(ready_m), 32'd1);
        req = 1'b1; rd_en = rd; wr_en = wr; addr = a; din = d;
        @(negedge clk);
        req = 1'b0;
        rd_en = 1'($urandom); wr_en = 1'($urandom);
        addr = 16'($urandom); din = 16'($urandom);
        e = !((rd ^ wr) && (a < 16'd256));
        if (!e && wr) begin
            model_mem[s][a[7:0]] = d;
            known[s][a[7:0]] = 1'b1;
        end
        if (!e && rd) model_dout[s] = model_mem[s][a[7:0]];
        lat = 1;
        while (!ack_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(wc_of(sel) + 2));
        check({tag, " err"}, 32'(err_m), 32'(e));
        check({tag, " data"}, 32'(dout_m), 32'(model_dout[s]));
        @(negedge clk);
        check({tag, " ack low"}, 32'({ack_m, err_m}), 32'd0);
        check({tag, " ready back"}, 32'(ready_m), 32'd1);
    endtask

    task automatic held_reads(input logic [15:0] a0, input logic [15:0] a1, input int n,
                              input string tag);
        int s;
        int cyc;
        int last;
        int got;
        logic [15:0] cur;
        s = sel ? 1 : 0;
        cyc = 0; last = 0; got = 0;
        cur = a0;
        req = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = cur;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack_m) begin
                check({tag, " data"}, 32'(dout_m), 32'(model_mem[s][cur[7:0]]));
                if (got > 0) check({tag, " interval"}, 32'(cyc - last), 32'(wc_of(sel) + 3));
                model_dout[s] = model_mem[s][cur[7:0]];
                last = cyc;
                got++;
                cur = (got % 2 == 1) ? a1 : a0;
                addr = cur;
                if (got == n) req = 1'b0;
            end
        end
        req = 1'b0;
        check({tag, " ack count"}, 32'(got), 32'(n));
        @(negedge clk);
        check({tag, " no extra accept"}, 32'(ready_m), 32'd1);
    endtask

    initial begin
        logic        r, w;
        logic [15:0] a;
        int          ack_seen;
        rst = 1'b0; req = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        addr = '0; din = '0; sel = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 256; j++) begin
                known[k][j] = 1'b0;
                model_mem[k][j] = 16'h0000;
            end

        // Reset values on both instances.
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check("reset ready", 32'(ready_m), 32'd1);
            check("reset ack/err", 32'({ack_m, err_m}), 32'd0);
            check("reset data", 32'(dout_m), 32'd0);
            check("reset state", 32'(state_m), 32'(MEM_IDLE));
        end

        // Directed write/read on WAIT_CYCLES=2.
        sel = 1'b0;
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF, "wr beef");
        access(1'b1, 1'b0, 16'h0010, 16'h0000, "rd beef");
        access(1'b0, 1'b1, 16'h0011, 16'h7E57, "wr 11");
        held_reads(16'h0010, 16'h0011, 6, "held2");

        // Error cases.
        access(1'b0, 1'b1, 16'h0000, 16'hA5A5, "wr 0");
        access(1'b0, 1'b1, 16'h0100, 16'h1111, "wr oob");
        access(1'b1, 1'b0, 16'h0000, 16'h0000, "rd 0 after oob");
        access(1'b1, 1'b1, 16'h0010, 16'h2222, "rd+wr");
        access(1'b0, 1'b0, 16'h0010, 16'h3333, "no op");
        access(1'b1, 1'b0, 16'hFF10, 16'h0000, "rd oob");
        access(1'b1, 1'b0, 16'h0010, 16'h0000, "rd 10 intact");

        // Reset in the middle of WAIT discards the pending write.
        access(1'b0, 1'b1, 16'h0020, 16'h5555, "wr 5555");
        @(negedge clk);
        req = 1'b1; rd_en = 1'b0; wr_en = 1'b1; addr = 16'h0020; din = 16'h1234;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("midwait ack", 32'(ack_m), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_dout[0] = 16'h0000;
        model_dout[1] = 16'h0000;
        check("post reset ready", 32'(ready_m), 32'd1);
        check("post reset data", 32'(dout_m), 32'd0);
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack_m) ack_seen++;
        end
        check("post reset no ack", 32'(ack_seen), 32'd0);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, "rd 5555");

        // Reset asserted together with a request: nothing is accepted.
        @(negedge clk);
        rst = 1'b1; req = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 16'h0010;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        check("rst+req ready", 32'(ready_m), 32'd1);
        model_dout[0] = 16'h0000;
        model_dout[1] = 16'h0000;
        @(negedge clk);
        check("rst+req idle", 32'({ready_m, ack_m}), 32'b10);

        // Random traffic on WAIT_CYCLES=2.
        for (int i = 0; i < 25; i++) begin
            r = 1'($urandom); w = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            if (r && !w && a < 16'd256 && !known[0][a[7:0]]) begin
                r = 1'b0; w = 1'b1;
            end
            access(r, w, a, 16'($urandom), "rand2");
        end

        // WAIT_CYCLES=0 instance: latency 1 wait cycle, throughput one per 3.
        sel = 1'b1;
        @(negedge clk);
        access(1'b0, 1'b1, 16'h0040, 16'hC0DE, "wc0 wr");
        access(1'b1, 1'b0, 16'h0040, 16'h0000, "wc0 rd");
        access(1'b0, 1'b1, 16'h0041, 16'hF00D, "wc0 wr2");
        held_reads(16'h0040, 16'h0041, 5, "held0");
        access(1'b1, 1'b1, 16'h0040, 16'h0000, "wc0 rd+wr");
        for (int i = 0; i < 20; i++) begin
            r = 1'($urandom); w = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            if (r && !w && a < 16'd256 && !known[1][a[7:0]]) begin
                r = 1'b0; w = 1'b1;
            end
            access(r, w, a, 16'($urandom), "rand0");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
